fetch_unit_pipe: RTL

- Parametrised successor to the single-cycle fetch stage. Owns the PC, issues pipelined requests to instruction memory over a valid/ready channel, and buffers in-order responses in a FIFO.
- Presents instructions to decode over a valid/ready handshake.
- Handles redirects (jump/call, return, interrupt via IVT) with flush and squashing of in-flight responses.
- Sits between the IMEM port and the decode stage.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit_pipe.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg : shared constants for the pipelined fetch unit
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam logic [1:0] REDIR_JUMP = 2'd0;
  localparam logic [1:0] REDIR_RET  = 2'd1;
  localparam logic [1:0] REDIR_INT  = 2'd2;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo : synchronous FIFO with push, pop, flush and occupancy count
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  assign w_full = (r_count == (c_ptr_w + 1)'(DEPTH));
  assign empty  = (r_count == '0);
  // flush wins over any same-cycle push or pop
  assign w_push = push && !flush && !w_full;
  assign w_pop  = pop && !flush && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      r_count <= r_count + (c_ptr_w + 1)'(w_push) - (c_ptr_w + 1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && !flush && w_full));

endmodule

`default_nettype wire

// File: rtl/fetch_unit_pipe.sv
// ============================================================================
// fetch_unit_pipe : PC owner, pipelined IMEM requester and decode-side FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit_pipe
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 16,
  parameter int                IDX_W    = 3,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redir_valid,
  input  logic [1:0]         redir_kind,
  input  logic [ADDR_W-1:0]  redir_target,
  input  logic [IDX_W-1:0]   int_index,
  input  logic [ADDR_W-1:0]  ivt_base,
  output logic               imem_req_valid,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic               dec_int,
  input  logic               dec_ready
);

  localparam int                 c_cnt_w     = $clog2(DEPTH) + 1;
  localparam logic [c_cnt_w:0]   c_depth_sum = (c_cnt_w + 1)'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth_cnt = c_cnt_w'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
    logic               int_flag;
  } entry_t;

  logic               r_run;
  logic [ADDR_W-1:0]  r_fetch_pc;
  logic [ADDR_W-1:0]  r_rsp_pc;
  logic [c_cnt_w-1:0] r_inflight;
  logic [c_cnt_w-1:0] r_drop_cnt;
  logic               r_int_pend;

  logic [ADDR_W-1:0]  w_target;
  logic [c_cnt_w:0]   w_credit_sum;
  logic [c_cnt_w-1:0] w_inflight_nxt;
  logic [c_cnt_w-1:0] w_count;
  logic               w_empty;
  logic               w_issue;
  logic               w_drop;
  logic               w_push;
  logic               w_pop;
  entry_t             w_push_entry;
  entry_t             w_head;

  always_comb begin
    w_target = redir_target;
    case (redir_kind)
      REDIR_JUMP, REDIR_RET: w_target = redir_target;
      REDIR_INT:             w_target = ivt_base + ADDR_W'(int_index);
      default:               w_target = redir_target;
    endcase
  end

  // Credit covers both buffered and still-owed words so the FIFO can never overflow
  assign w_credit_sum   = {1'b0, r_inflight} + {1'b0, w_count};
  assign imem_req_valid = r_run && !redir_valid && (w_credit_sum < c_depth_sum) &&
                          ((r_drop_cnt == '0) || (r_inflight < c_depth_cnt));
  assign imem_req_addr  = r_fetch_pc;

  assign w_issue        = imem_req_valid && imem_req_ready;
  assign w_drop         = imem_rsp_valid && (r_drop_cnt != '0);
  assign w_push         = imem_rsp_valid && !w_drop;
  assign w_pop          = dec_valid && dec_ready;
  assign w_inflight_nxt = r_inflight + c_cnt_w'(w_issue) - c_cnt_w'(imem_rsp_valid);

  assign w_push_entry.instr    = imem_rsp_data;
  assign w_push_entry.pc       = r_rsp_pc;
  assign w_push_entry.int_flag = r_int_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
      r_int_pend <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_inflight_nxt;
      if (redir_valid) begin
        // No issue happens in a redirect cycle, so every remaining owed word is stale
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= w_inflight_nxt;
        r_int_pend <= (redir_kind == REDIR_INT);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        if (w_drop)  r_drop_cnt <= r_drop_cnt - c_cnt_w'(1);
        if (w_push) begin
          r_rsp_pc   <= r_rsp_pc + ADDR_W'(1);
          r_int_pend <= 1'b0;
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redir_valid),
    .push  (w_push),
    .wdata (w_push_entry),
    .pop   (w_pop),
    .rdata (w_head),
    .count (w_count),
    .empty (w_empty)
  );

  assign dec_valid = !w_empty && !redir_valid;
  assign dec_instr = w_empty ? '0 : w_head.instr;
  assign dec_pc    = w_empty ? '0 : w_head.pc;
  assign dec_int   = w_empty ? 1'b0 : w_head.int_flag;

endmodule

`default_nettype wire
